add_share_arb: RTL and testbench

Round-robin arbiter and result register that shares the single 16-bit recursive doubling adder (`double`) between NREQ requesters. Each requester presents operands and a carry-in with a level request. The block grants one requester per cycle, drives the shared adder with that requester's operands, and captures the 17-bit sum with the requester's index into an output register. The register has a valid/ready handshake toward the consumer.

---
 rtl/add_arb_pkg.sv | 23 ++
 rtl/double.sv | 71 +++++++
 rtl/rr_pick.sv | 45 ++++
 rtl/add_share_arb.sv | 113 +++++++++++
 tb/tb_add_share_arb.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_arb_pkg.sv
// ----------------------------------------------------------------------------
// add_arb_pkg
// Shared constants for the adder-sharing arbiter.
//   W     : operand width of the shared adder (fixed at 16)
//   RES_W : result width, operand width plus the carry-out bit
// ----------------------------------------------------------------------------
package add_arb_pkg;

  localparam int W     = 16;
  localparam int RES_W = W + 1;

  // Reference-free helper: unsigned sum of two operands plus carry-in,
  // returned at full result width. Used only where a plain behavioural
  // expression is wanted next to the structural adder.
  function automatic logic [RES_W-1:0] add_full(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin
  );
    add_full = {1'b0, a} + {1'b0, b} + {{(RES_W-1){1'b0}}, cin};
  endfunction

endpackage

// File: rtl/double.sv
// ----------------------------------------------------------------------------
// double
// 16-bit recursive doubling (Kogge-Stone) adder, purely combinational.
// Ports:
//   a, b : 16-bit unsigned operands
//   cin  : carry-in
//   sum  : 17-bit result, carry-out in the MSB
// ----------------------------------------------------------------------------
module double
  import add_arb_pkg::*;
(
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             cin,
  output logic [RES_W-1:0] sum
);

  localparam int LEVELS = 4;  // log2(16) prefix levels

  logic [W-1:0] g [0:LEVELS];
  logic [W-1:0] p [0:LEVELS-1];
  logic [W-1:0] c;

  // Prefix tree: each level doubles the span covered by group generate/propagate.
  always_comb begin
    for (int k = 0; k <= LEVELS; k++) begin
      g[k] = '0;
    end
    for (int k = 0; k < LEVELS; k++) begin
      p[k] = '0;
    end
    c = '0;

    p[0] = a ^ b;
    g[0] = a & b;
    // Fold the carry-in into bit 0 so the tree carries it like any generate.
    g[0][0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);

    for (int k = 0; k < LEVELS; k++) begin
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << k)) begin
          g[k+1][i] = g[k][i] | (p[k][i] & g[k][i - (1 << k)]);
          if (k < LEVELS - 1) begin
            p[k+1][i] = p[k][i] & p[k][i - (1 << k)];
          end else begin
            // Last level's group propagate is never consumed.
          end
        end else begin
          g[k+1][i] = g[k][i];
          if (k < LEVELS - 1) begin
            p[k+1][i] = p[k][i];
          end else begin
            // Last level's group propagate is never consumed.
          end
        end
      end
    end

    // Carry into bit i is the group generate of bits i-1..0 (with cin).
    c[0] = cin;
    for (int i = 1; i < W; i++) begin
      c[i] = g[LEVELS][i-1];
    end
  end

  // Sum bits and carry-out.
  always_comb begin
    sum = {g[LEVELS][W-1], p[0] ^ c};
  end

endmodule

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches req starting at ptr
// and wrapping modulo NREQ; the first set bit wins.
// Ports:
//   req : request vector
//   ptr : index with highest priority this cycle (0..NREQ-1)
//   gnt : one-hot grant, zero when no request is set
//   sel : binary index of the winner, zero when no request is set
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  sel
);

  // Walk offsets from farthest to nearest so the nearest set bit overwrites
  // any earlier hit and ends up as the winner.
  always_comb begin
    int idx;
    gnt = '0;
    sel = '0;
    idx = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (idx < NREQ && req[idx]) begin
        sel = IDW'(idx);
        gnt = NREQ'(1) << idx;
      end else begin
        sel = sel;
        gnt = gnt;
      end
    end
  end

endmodule

// File: rtl/add_share_arb.sv
// ----------------------------------------------------------------------------
// add_share_arb
// Shares one 16-bit adder between NREQ requesters. A round-robin picker
// grants one requester per cycle when the result register can take a new
// value; the granted operands go through the adder and the 17-bit sum is
// captured with the requester index. The result register offers the value
// to a consumer with a valid/ready handshake.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   req        : per-requester request level
//   a_in, b_in : operand slices, slice i belongs to requester i
//   cin_in     : carry-in per requester
//   gnt        : one-hot grant (combinational), operands sampled on its edge
//   res_valid  : result register holds an unconsumed result
//   res_ready  : consumer accepts the result when res_valid is high
//   res_sum    : registered a+b+cin with carry-out in the MSB
//   res_id     : index of the requester that produced res_sum
// ----------------------------------------------------------------------------
module add_share_arb
  import add_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   a_in,
  input  logic [NREQ*W-1:0]   b_in,
  input  logic [NREQ-1:0]     cin_in,
  output logic [NREQ-1:0]     gnt,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RES_W-1:0]    res_sum,
  output logic [IDW-1:0]      res_id
);

  logic [IDW-1:0]   ptr;
  logic [NREQ-1:0]  pick_gnt;
  logic [IDW-1:0]   sel;
  logic             slot_free;
  logic             grant_any;
  logic [W-1:0]     a_sel;
  logic [W-1:0]     b_sel;
  logic             cin_sel;
  logic [RES_W-1:0] add_out;
  logic [IDW-1:0]   ptr_next;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .sel (sel)
  );

  // The slot can take a new result if it is empty or being drained this edge.
  always_comb begin
    slot_free = !res_valid || res_ready;
  end

  // Grant is suppressed under backpressure and while reset is held.
  always_comb begin
    if (!rst && slot_free) begin
      gnt = pick_gnt;
    end else begin
      gnt = '0;
    end
    grant_any = |gnt;
  end

  // Operand mux in front of the shared adder.
  always_comb begin
    a_sel   = a_in[int'(sel)*W +: W];
    b_sel   = b_in[int'(sel)*W +: W];
    cin_sel = cin_in[sel];
  end

  double u_add (
    .a   (a_sel),
    .b   (b_sel),
    .cin (cin_sel),
    .sum (add_out)
  );

  // The requester just served drops to lowest priority.
  always_comb begin
    if (int'(sel) == NREQ - 1) begin
      ptr_next = '0;
    end else begin
      ptr_next = sel + IDW'(1);
    end
  end

  // Result register, handshake state and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= '0;
      ptr       <= '0;
    end else if (grant_any) begin
      res_valid <= 1'b1;
      res_sum   <= add_out;
      res_id    <= sel;
      ptr       <= ptr_next;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end else begin
      res_valid <= res_valid;
    end
  end

endmodule

// File: tb/tb_add_share_arb.sv
module tb_add_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   cin_in;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic              res_ready;
  logic [W:0]        res_sum;
  logic [1:0]        res_id;

  int n_cmp = 0;
  int n_err = 0;

  add_share_arb #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin_in    (cin_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic c);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
    cin_in[i]      = c;
  endtask

  // Inputs change #1 after a rising edge; checks happen on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    res_ready = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    res_ready = 1'b1;
    a_in = '0; b_in = '0; cin_in = '0;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    n_cmp++; if (res_sum !== 17'd0) begin n_err++; $display("FAIL reset_sum got=%0d exp=0", res_sum); end
    n_cmp++; if (res_id !== 2'd0) begin n_err++; $display("FAIL reset_id got=%0d exp=0", res_id); end
    next_cycle();
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_single();
    req = 4'b0100;
    set_op(2, 16'd65535, 16'd56, 1'b0);
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    next_cycle();
    req = 4'b0000;
    @(negedge clk);
    n_cmp++; if (res_sum !== 17'h10037) begin n_err++; $display("FAIL single_sum got=%0d exp=65591", res_sum); end
    n_cmp++; if (res_id !== 2'd2) begin n_err++; $display("FAIL single_id got=%0d exp=2", res_id); end
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", res_valid); end
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL single_gnt_after got=%b exp=0000", gnt); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got=%b exp=0", res_valid); end
  endtask

  task automatic test_round_robin();
    logic [16:0] exp_sum [0:3];
    exp_sum[0] = 17'd1407; exp_sum[1] = 17'd1408; exp_sum[2] = 17'd1409; exp_sum[3] = 17'd1410;
    do_reset();
    set_op(0, 16'd600, 16'd807, 1'b0);
    set_op(1, 16'd600, 16'd807, 1'b1);
    set_op(2, 16'd602, 16'd807, 1'b0);
    set_op(3, 16'd602, 16'd807, 1'b1);
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt !== (4'b0001 << (k % 4))) begin
        n_err++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, gnt, 4'b0001 << (k % 4));
      end
      if (k > 0) begin
        n_cmp++;
        if (res_sum !== exp_sum[(k-1) % 4] || res_id !== 2'((k-1) % 4) || res_valid !== 1'b1) begin
          n_err++; $display("FAIL rr_res[%0d] got sum=%0d id=%0d v=%b exp sum=%0d id=%0d v=1",
                            k, res_sum, res_id, res_valid, exp_sum[(k-1) % 4], (k-1) % 4);
        end
      end
      next_cycle();
    end
    req = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (res_sum !== 17'd1408 || res_id !== 2'd1) begin
      n_err++; $display("FAIL rr_last got sum=%0d id=%0d exp sum=1408 id=1", res_sum, res_id);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0001;
    set_op(0, 16'd0, 16'd0, 1'b1);
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL bp_first_gnt got=%b exp=0001", gnt); end
    next_cycle();
    res_ready = 1'b0;
    set_op(0, 16'd5, 16'd6, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if (gnt !== 4'b0000 || res_sum !== 17'd1 || res_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold[%0d] got gnt=%b sum=%0d v=%b exp gnt=0000 sum=1 v=1", k, gnt, res_sum, res_valid);
      end
      next_cycle();
    end
    res_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL bp_release_gnt got=%b exp=0001", gnt); end
    next_cycle();
    req = 4'b0000;
    res_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (res_sum !== 17'd11 || res_valid !== 1'b1 || res_id !== 2'd0) begin
      n_err++; $display("FAIL bp_new got sum=%0d v=%b id=%0d exp sum=11 v=1 id=0", res_sum, res_valid, res_id);
    end
    res_ready = 1'b1;
  endtask

  task automatic test_fairness_idle();
    do_reset();
    req = 4'b0010;
    set_op(1, 16'd1025, 16'd807, 1'b1);
    set_op(0, 16'd10, 16'd20, 1'b0);
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL fair_gnt1 got=%b exp=0010", gnt); end
    next_cycle();
    req = 4'b0000;
    @(negedge clk);
    n_cmp++; if (res_sum !== 17'd1833 || res_id !== 2'd1) begin
      n_err++; $display("FAIL fair_sum got sum=%0d id=%0d exp sum=1833 id=1", res_sum, res_id);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL fair_idle[%0d] got=%b exp=0000", k, gnt); end
    end
    next_cycle();
    req = 4'b0011;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL fair_wrap got=%b exp=0001", gnt); end
    next_cycle();
    req = 4'b0010;
    @(negedge clk);
    n_cmp++; if (res_sum !== 17'd30 || res_id !== 2'd0) begin
      n_err++; $display("FAIL fair_r0 got sum=%0d id=%0d exp sum=30 id=0", res_sum, res_id);
    end
    n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL fair_then1 got=%b exp=0010", gnt); end
    next_cycle();
    req = 4'b0000;
  endtask

  task automatic test_reset_mid();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_op(i, 16'd100, 16'd200, 1'b0);
    res_ready = 1'b1;
    next_cycle();
    res_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid got=%b exp=1", res_valid); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (res_valid !== 1'b0 || gnt !== 4'b0000 || res_sum !== 17'd0) begin
      n_err++; $display("FAIL rmid_async got v=%b gnt=%b sum=%0d exp v=0 gnt=0000 sum=0", res_valid, gnt, res_sum);
    end
    res_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rmid_held_gnt got=%b exp=0000", gnt); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL rmid_first got=%b exp=0001", gnt); end
    next_cycle();
    req = 4'b0000;
  endtask

  task automatic test_random();
    logic [15:0] ma [0:NREQ-1];
    logic [15:0] mb [0:NREQ-1];
    logic        mc [0:NREQ-1];
    int          waitc [0:NREQ-1];
    int          mptr;
    logic        mvalid;
    logic [16:0] msum;
    int          mid;
    logic [NREQ-1:0] egnt;
    int          esel;
    do_reset();
    mptr = 0; mvalid = 1'b0; msum = '0; mid = 0;
    egnt = '0; esel = 0;
    for (int i = 0; i < NREQ; i++) begin
      ma[i] = 16'($urandom); mb[i] = 16'($urandom); mc[i] = 1'($urandom);
      set_op(i, ma[i], mb[i], mc[i]);
      waitc[i] = 0;
    end
    req = 4'($urandom);
    res_ready = 1'($urandom);
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      egnt = '0; esel = 0;
      if (!mvalid || res_ready) begin
        for (int off = NREQ - 1; off >= 0; off--) begin
          if (req[(mptr + off) % NREQ]) begin
            esel = (mptr + off) % NREQ;
            egnt = 4'b0001 << esel;
          end
        end
      end
      n_cmp++;
      if (gnt !== egnt) begin
        n_err++; $display("FAIL rand_gnt[%0d] got=%b exp=%b", cyc, gnt, egnt);
      end
      if (egnt != 4'b0000) begin
        for (int i = 0; i < NREQ; i++) begin
          if (i != esel && req[i]) waitc[i]++;
        end
        waitc[esel] = 0;
        mvalid = 1'b1;
        msum = {1'b0, ma[esel]} + {1'b0, mb[esel]} + {16'd0, mc[esel]};
        mid = esel;
        mptr = (esel + 1) % NREQ;
      end else if (mvalid && res_ready) begin
        mvalid = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        n_cmp++;
        if (waitc[i] > NREQ) begin
          n_err++; $display("FAIL rand_starve[%0d] req=%0d waited=%0d grants", cyc, i, waitc[i]);
        end
      end
      next_cycle();
      n_cmp++;
      if (res_valid !== mvalid || (mvalid && (res_sum !== msum || res_id !== 2'(mid)))) begin
        n_err++; $display("FAIL rand_res[%0d] got v=%b sum=%0d id=%0d exp v=%b sum=%0d id=%0d",
                          cyc, res_valid, res_sum, res_id, mvalid, msum, mid);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || egnt[i]) begin
          req[i] = 1'($urandom);
          ma[i] = 16'($urandom); mb[i] = 16'($urandom); mc[i] = 1'($urandom);
          set_op(i, ma[i], mb[i], mc[i]);
          waitc[i] = 0;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
    end
    req = '0;
    res_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fairness_idle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
